// File: rtl/bsg_mem_1rw_sync_arbiter_pkg.sv
// Shared types and helpers for the 1RW SRAM arbiter and its response slots.
package bsg_mem_1rw_sync_arbiter_pkg;

  // Occupancy of a one-entry response slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Address/index width that never collapses to zero bits.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_mem_arb_resp_slot.sv
// One-entry bypassing response buffer. Read data arriving on fill is shown
// immediately; if it is not consumed in that cycle it is captured and held
// until yumi. The slot state doubles as the occupancy flag for eligibility.
module bsg_mem_arb_resp_slot
  import bsg_mem_1rw_sync_arbiter_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               fill_v_i,
  input  logic [width_p-1:0] fill_data_i,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output slot_state_e        state_o
);

  slot_state_e        state_q, state_d;
  logic [width_p-1:0] data_q, data_d;

  // Next state, capture decision and bypass/held output select.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    v_o     = 1'b0;
    data_o  = data_q;
    case (state_q)
      SLOT_EMPTY: begin
        v_o    = fill_v_i;
        data_o = fill_data_i;
        if (fill_v_i && !yumi_i) begin
          state_d = SLOT_FULL;
          data_d  = fill_data_i;
        end
      end
      SLOT_FULL: begin
        v_o    = 1'b1;
        data_o = data_q;
        if (yumi_i) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  // Occupancy register; reset drops any held entry.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Held data needs no reset: it is only visible while the slot is full.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/bsg_mem_1rw_sync_arbiter.sv
// Round-robin arbiter sharing one synchronous 1RW SRAM port among requesters,
// with a bypassing one-entry read response slot per requester.
//
// Handshake: a request transfers on a cycle where req_v_i[i] && req_yumi_o[i];
// the requester holds its fields stable until then. A read response transfers
// on a cycle where resp_v_o[i] && resp_yumi_i[i]; resp_yumi_i[i] may only be
// raised while resp_v_o[i] is high.
module bsg_mem_1rw_sync_arbiter
  import bsg_mem_1rw_sync_arbiter_pkg::*;
#(
  parameter  int num_req_p     = 2,
  parameter  int width_p       = 32,
  parameter  int els_p         = 64,
  localparam int mask_width_lp = width_p / 8,
  localparam int addr_w_lp     = safe_clog2(els_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p-1:0]               req_v_i,
  input  logic [num_req_p-1:0]               req_w_i,
  input  logic [num_req_p*addr_w_lp-1:0]     req_addr_i,
  input  logic [num_req_p*width_p-1:0]       req_data_i,
  input  logic [num_req_p*mask_width_lp-1:0] req_mask_i,
  output logic [num_req_p-1:0]               req_yumi_o,
  output logic                               mem_v_o,
  output logic                               mem_w_o,
  output logic [addr_w_lp-1:0]               mem_addr_o,
  output logic [width_p-1:0]                 mem_data_o,
  output logic [mask_width_lp-1:0]           mem_mask_o,
  input  logic [width_p-1:0]                 mem_data_i,
  output logic [num_req_p-1:0]               resp_v_o,
  output logic [num_req_p*width_p-1:0]       resp_data_o,
  input  logic [num_req_p-1:0]               resp_yumi_i
);

  localparam int id_w_lp = safe_clog2(num_req_p);

  logic [id_w_lp-1:0]   ptr_q, ptr_d;
  logic                 infl_v_q, infl_v_d;
  logic [id_w_lp-1:0]   infl_id_q, infl_id_d;
  logic [num_req_p-1:0] infl_hit, fill_v, slot_full, elig;
  logic                 gnt_v;
  logic [id_w_lp-1:0]   gnt_id, scan_id;
  slot_state_e          slot_state [num_req_p];

  for (genvar g = 0; g < num_req_p; g++) begin : g_slot
    assign infl_hit[g]  = infl_v_q && (infl_id_q == id_w_lp'(g));
    // Reset discards the in-flight read so its data is never presented.
    assign fill_v[g]    = reset_n_i && infl_hit[g];
    assign slot_full[g] = (slot_state[g] == SLOT_FULL);

    bsg_mem_arb_resp_slot #(.width_p(width_p)) slot (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .fill_v_i   (fill_v[g]),
      .fill_data_i(mem_data_i),
      .yumi_i     (resp_yumi_i[g]),
      .v_o        (resp_v_o[g]),
      .data_o     (resp_data_o[g*width_p +: width_p]),
      .state_o    (slot_state[g])
    );
  end

  // A read may only win if its slot is guaranteed free next cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < num_req_p; i++) begin
      elig[i] = reset_n_i && req_v_i[i] &&
                (req_w_i[i] || (!infl_hit[i] && (!slot_full[i] || resp_yumi_i[i])));
    end
  end

  // Round-robin scan starting at the pointer; first eligible requester wins.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_id  = '0;
    scan_id = '0;
    for (int k = 0; k < num_req_p; k++) begin
      scan_id = id_w_lp'((int'(ptr_q) + k) % num_req_p);
      if (!gnt_v && elig[scan_id]) begin
        gnt_v  = 1'b1;
        gnt_id = scan_id;
      end
    end
  end

  // Grant vector, SRAM mux and next pointer / in-flight tag.
  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      req_yumi_o[i] = gnt_v && (gnt_id == id_w_lp'(i));
    end
    mem_v_o    = gnt_v;
    mem_w_o    = gnt_v && req_w_i[gnt_id];
    mem_addr_o = req_addr_i[gnt_id*addr_w_lp +: addr_w_lp];
    mem_data_o = req_data_i[gnt_id*width_p +: width_p];
    mem_mask_o = req_mask_i[gnt_id*mask_width_lp +: mask_width_lp];
    ptr_d      = ptr_q;
    if (gnt_v) begin
      ptr_d = (gnt_id == id_w_lp'(num_req_p - 1)) ? '0 : gnt_id + 1'b1;
    end
    infl_v_d  = gnt_v && !req_w_i[gnt_id];
    infl_id_d = gnt_id;
  end

  // Arbitration pointer and in-flight read tag.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ptr_q     <= '0;
      infl_v_q  <= 1'b0;
      infl_id_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      infl_v_q  <= infl_v_d;
      infl_id_q <= infl_id_d;
    end
  end

`ifndef SYNTHESIS
  // Consuming a response that is not being offered is a protocol violation.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ((resp_yumi_i & ~resp_v_o) == '0)
        else $error("resp_yumi_i=%b raised while resp_v_o=%b", resp_yumi_i, resp_v_o);
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_arbiter.sv
// Directed bench for the 1RW SRAM arbiter with a behavioural SRAM and a
// per-requester expected-response queue checked by an independent monitor.
module tb_bsg_mem_1rw_sync_arbiter;

  localparam int NR = 2;
  localparam int W  = 32;
  localparam int EL = 32;
  localparam int AW = 5;
  localparam int MW = 4;

  logic              clk;
  logic              reset_n;
  logic [NR-1:0]     req_v, req_w, req_yumi;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*W-1:0]   req_data;
  logic [NR*MW-1:0]  req_mask;
  logic              mem_v, mem_w;
  logic [AW-1:0]     mem_addr;
  logic [W-1:0]      mem_wdata, mem_rdata;
  logic [MW-1:0]     mem_mask;
  logic [NR-1:0]     resp_v, resp_yumi, yumi_en;
  logic [NR*W-1:0]   resp_data;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] sram [EL];
  int n_checks;
  int n_fail;

  bsg_mem_1rw_sync_arbiter #(.num_req_p(NR), .width_p(W), .els_p(EL)) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .req_v_i    (req_v),
    .req_w_i    (req_w),
    .req_addr_i (req_addr),
    .req_data_i (req_data),
    .req_mask_i (req_mask),
    .req_yumi_o (req_yumi),
    .mem_v_o    (mem_v),
    .mem_w_o    (mem_w),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_wdata),
    .mem_mask_o (mem_mask),
    .mem_data_i (mem_rdata),
    .resp_v_o   (resp_v),
    .resp_data_o(resp_data),
    .resp_yumi_i(resp_yumi)
  );

  // Consumers take a response only while it is offered.
  assign resp_yumi = resp_v & yumi_en;

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous 1RW SRAM with byte mask.
  always @(posedge clk) begin
    if (mem_v) begin
      if (mem_w) begin
        for (int b = 0; b < MW; b++) begin
          if (mem_mask[b]) sram[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
        end
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [W-1:0] d, input logic [MW-1:0] m);
    req_v[i]             = v;
    req_w[i]             = w;
    req_addr[i*AW +: AW] = a;
    req_data[i*W +: W]   = d;
    req_mask[i*MW +: MW] = m;
  endtask

  // Scoreboard monitor: every consumed response must match the queue head.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < NR; i++) begin
        if (resp_v[i] && resp_yumi[i]) begin
          if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_unexpected%0d: got data %0h, expected no response", i,
                     resp_data[i*W +: W]);
          end else begin
            mon_exp = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("resp_data%0d", i), 64'(resp_data[i*W +: W]), 64'(mon_exp));
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < EL; i++) sram[i] = '0;
    sram[3]  = 32'hFFFF_FFFF;
    sram[4]  = 32'hA0A0_0004;
    sram[8]  = 32'hB0B0_0008;
    sram[16] = 32'hDEAD_BEEF;
    mem_rdata = '0;
    req_v = '0; req_w = '0; req_addr = '0; req_data = '0; req_mask = '0;
    yumi_en = 2'b11;
    reset_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 5'h04, '0, '0);
    set_req(1, 1'b1, 1'b0, 5'h08, '0, '0);

    // Reset with both requesters active: no grants, no SRAM access.
    repeat (3) begin
      @(negedge clk);
      check("rst_yumi", 64'(req_yumi), 64'h0);
      check("rst_mem_v", 64'(mem_v), 64'h0);
    end
    step();
    reset_n = 1'b1;

    // Contention: grants alternate 0,1,0,1,... starting with requester 0.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) check("post_rst_resp_v", 64'(resp_v), 64'h0);
      if (k % 2 == 0) begin
        check("cont_grant", 64'(req_yumi), 64'h1);
        exp_q0.push_back(32'hA0A0_0004);
      end else begin
        check("cont_grant", 64'(req_yumi), 64'h2);
        exp_q1.push_back(32'hB0B0_0008);
      end
      step();
    end
    req_v = '0;
    @(negedge clk);
    check("cont_idle", 64'(req_yumi), 64'h0);
    step();

    // Backpressure on requester 0 while requester 1 keeps reading.
    yumi_en = 2'b10;
    set_req(0, 1'b1, 1'b0, 5'h10, '0, '0);
    set_req(1, 1'b1, 1'b0, 5'h08, '0, '0);
    @(negedge clk);
    check("bp_first_grant", 64'(req_yumi), 64'h1);
    exp_q0.push_back(32'hDEAD_BEEF);
    step();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c % 2 == 1) begin
        check("bp_grant", 64'(req_yumi), 64'h2);
        exp_q1.push_back(32'hB0B0_0008);
      end else begin
        check("bp_grant", 64'(req_yumi), 64'h0);
      end
      check("bp_hold_v", 64'(resp_v[0]), 64'h1);
      check("bp_hold_data", 64'(resp_data[31:0]), 64'hDEAD_BEEF);
      step();
    end
    yumi_en = 2'b11;
    @(negedge clk);
    check("bp_regrant", 64'(req_yumi), 64'h1);
    exp_q0.push_back(32'hDEAD_BEEF);
    step();
    req_v = '0;
    @(negedge clk);
    check("bp_idle", 64'(req_yumi), 64'h0);
    step();

    // Masked write then back-to-back read of the same address.
    set_req(1, 1'b1, 1'b1, 5'h03, 32'h1234_5678, 4'b0011);
    @(negedge clk);
    check("wr_grant", 64'(req_yumi), 64'h2);
    check("wr_mem_v", 64'(mem_v), 64'h1);
    check("wr_mem_w", 64'(mem_w), 64'h1);
    check("wr_mem_addr", 64'(mem_addr), 64'h3);
    check("wr_mem_data", 64'(mem_wdata), 64'h1234_5678);
    check("wr_mem_mask", 64'(mem_mask), 64'h3);
    step();
    set_req(1, 1'b1, 1'b0, 5'h03, '0, '0);
    @(negedge clk);
    check("rd_after_wr_grant", 64'(req_yumi), 64'h2);
    check("rd_after_wr_mem_w", 64'(mem_w), 64'h0);
    check("rd_after_wr_addr", 64'(mem_addr), 64'h3);
    exp_q1.push_back(32'hFFFF_5678);
    step();
    req_v = '0;
    @(negedge clk);
    step();

    // A write from a requester with an occupied slot is not blocked.
    yumi_en = 2'b10;
    set_req(0, 1'b1, 1'b0, 5'h04, '0, '0);
    @(negedge clk);
    check("slot_fill_grant", 64'(req_yumi), 64'h1);
    exp_q0.push_back(32'hA0A0_0004);
    step();
    req_v = '0;
    @(negedge clk);
    step();
    set_req(0, 1'b1, 1'b1, 5'h05, 32'h55AA_55AA, 4'b1111);
    @(negedge clk);
    check("wr_bypass_grant", 64'(req_yumi), 64'h1);
    check("wr_bypass_mem_w", 64'(mem_w), 64'h1);
    check("wr_bypass_resp_v", 64'(resp_v[0]), 64'h1);
    check("wr_bypass_resp_data", 64'(resp_data[31:0]), 64'hA0A0_0004);
    step();
    req_v = '0;
    @(negedge clk);
    check("wr_after_resp_v", 64'(resp_v[0]), 64'h1);
    check("wr_after_resp_data", 64'(resp_data[31:0]), 64'hA0A0_0004);
    step();
    yumi_en = 2'b11;
    @(negedge clk);
    step();
    set_req(0, 1'b1, 1'b0, 5'h05, '0, '0);
    @(negedge clk);
    check("rd_back_grant", 64'(req_yumi), 64'h1);
    exp_q0.push_back(32'h55AA_55AA);
    step();
    req_v = '0;
    @(negedge clk);
    step();

    // Reset during an in-flight read: its data never appears.
    set_req(0, 1'b1, 1'b0, 5'h04, '0, '0);
    @(negedge clk);
    check("rst_mid_grant", 64'(req_yumi), 64'h1);
    step();
    reset_n = 1'b0;
    req_v   = '0;
    @(negedge clk);
    check("rst_mid_resp_v", 64'(resp_v), 64'h0);
    step();
    reset_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 5'h04, '0, '0);
    set_req(1, 1'b1, 1'b0, 5'h08, '0, '0);
    @(negedge clk);
    check("rst_after_resp_v", 64'(resp_v), 64'h0);
    check("rst_after_ptr_grant", 64'(req_yumi), 64'h1);
    exp_q0.push_back(32'hA0A0_0004);
    step();
    req_v = '0;
    @(negedge clk);
    check("rst_after_resp_pulse", 64'(resp_v), 64'h1);
    step();
    @(negedge clk);
    check("rst_after_quiet", 64'(resp_v), 64'h0);
    step();

    // Every expected response must have been delivered.
    check("exp_q0_drained", 64'(exp_q0.size()), 64'h0);
    check("exp_q1_drained", 64'(exp_q1.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_mem_1rw_sync_arbiter.md
Name: bsg_mem_1rw_sync_arbiter

Overview:
- Shares one synchronous 1RW SRAM port among num_req_p requesters using round-robin arbitration.
- Read data arrives from the SRAM one cycle after the access. The block presents it to the owning requester in that same cycle through a bypass path. If the requester does not consume it then, the block holds it in a one-entry per-requester response slot until consumed.
- Sits between cache/engine clients and a bsg_mem_1rw_sync instance.

Parameters:
- num_req_p, 2, number of requesters (>=2).
- width_p, none (required), data width in bits; must be a multiple of 8.
- els_p, none (required), SRAM depth; addr width = `BSG_SAFE_CLOG2(els_p).
- mask_width_lp, width_p/8, write byte-mask width (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous, active-low reset.
- req_v_i  in  num_req_p  per-requester request valid.
- req_w_i  in  num_req_p  1=write, 0=read.
- req_addr_i  in  num_req_p*addr_w  request addresses.
- req_data_i  in  num_req_p*width_p  write data.
- req_mask_i  in  num_req_p*mask_width_lp  write byte masks.
- req_yumi_o  out  num_req_p  one-hot grant; request consumed this cycle.
- mem_v_o  out  1  SRAM access enable.
- mem_w_o  out  1  SRAM write enable.
- mem_addr_o  out  addr_w  SRAM address.
- mem_data_o  out  width_p  SRAM write data.
- mem_mask_o  out  mask_width_lp  SRAM write mask.
- mem_data_i  in  width_p  SRAM read data, valid the cycle after a read.
- resp_v_o  out  num_req_p  per-requester read response valid.
- resp_data_o  out  num_req_p*width_p  per-requester read data.
- resp_yumi_i  in  num_req_p  response consumed.

Behaviour:
- Reset: while reset_n_i=0, req_yumi_o=0 and mem_v_o=0 (combinational gating). At the clock edge with reset_n_i=0: RR pointer<=0, all response slots empty, in-flight read tag cleared. Cycle after reset: resp_v_o=0.
- Eligibility:
  - Write requester i is eligible whenever req_v_i[i]=1.
  - Read requester i is eligible only if its response slot will be free next cycle. The slot is free if it is empty and no read for i is in flight, or if it is occupied and resp_yumi_i[i]=1 this cycle with no read for i in flight.
  - At most one outstanding read per requester.
- Arbitration:
  - Round-robin among eligible requesters, starting at the RR pointer.
  - On a grant to i, pointer <= (i+1) mod num_req_p. With no grant, the pointer holds.
  - req_yumi_o is one-hot or zero. It may depend combinationally on req_v_i, req_w_i and resp_yumi_i.
- SRAM drive: mem_v_o = |req_yumi_o. mem_w_o, mem_addr_o, mem_data_o and mem_mask_o are muxed from the granted requester. When idle, mem_w_o=0 and the other fields are don't-care.
- Read timing:
  - Grant read to i in cycle N. The in-flight register records {v=1, id=i}.
  - Cycle N+1: resp_v_o[i]=1 and resp_data_o[i]=mem_data_i (bypass).
  - If resp_yumi_i[i]=1 in N+1, the slot stays empty. Otherwise, at the end of N+1 mem_data_i is latched and resp_v_o[i] holds with stable data until yumi.
- Writes produce no response and do not touch the slots.
- Simultaneous events:
  - A requester's slot dequeue and a new read grant to the same requester in the same cycle are legal.
  - Back-to-back grants to different requesters every cycle give full throughput.
  - A read to address A granted the cycle after a write to A returns the new data.
- Reset mid-operation: an in-flight read is discarded and its data is never presented. Slot contents are dropped.
- Asserting resp_yumi_i[i] while resp_v_o[i]=0 is illegal; a simulation assertion flags it.

Decomposition:
- No shared package is needed. The address width is a localparam, and the request fields are packed arrays.
- One natural sub-module, bsg_mem_arb_resp_slot: a one-entry bypassing response buffer with an enable. It is instantiated num_req_p times and outputs an occupancy flag used for eligibility.
- Round-robin selection reuses the existing arbiter primitive where available. Otherwise it is a local priority rotate.

Test Plan:
- Reset then idle: reset_n_i=0 for 3 cycles with req_v_i=2'b11 -> req_yumi_o=0, mem_v_o=0. After release -> resp_v_o=0, and requester 0 is granted first.
- Contention: both requesters issue reads to 0x4 and 0x8 continuously with resp_yumi_i=2'b11 -> grants alternate 0,1,0,1. Each resp_v_o pulses one cycle after its grant with the correct data.
- Backpressure: requester 0 reads 0x10 (data 0xDEADBEEF) with resp_yumi_i[0]=0 for 5 cycles -> resp data is held stable, requester 0 receives no further read grants, and requester 1 keeps being granted. Yumi in cycle 6 -> requester 0 is regranted in that same cycle.
- Write-then-read: requester 1 writes 0x3 with data 0x12345678 and mask 4'b0011 over old 0xFFFFFFFF, then reads 0x3 -> returns 0xFFFF5678.
- Writes bypass slots: requester 0 has an occupied slot and issues a write -> it is granted immediately, and resp_v_o[0] stays asserted with unchanged data.
- Reset mid-read: reset_n_i=0 in the cycle after a read grant -> resp_v_o stays 0 after reset, with no stale data.
